update_field: RTL and testbench

UPDATE_FIELD -- requirements
Module: update_field

---
 rtl/update_field.sv | 219 +++++++++++++++++++++
 tb/tb_update_field.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/update_field.sv
// Converts one cursor drag step into a normalised direction/magnitude word and
// writes it to the field RAM cell under the cursor, using serial restoring division.
module update_field #(
    parameter int FIELD_WIDTH  = 8,
    parameter int FIELD_HEIGHT = 6,
    parameter int FIELD_DATAW  = 96,
    parameter int CELL_SHIFT   = 4,
    localparam int FIELD_ADDRW = $clog2(FIELD_WIDTH * FIELD_HEIGHT)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   done,
    output logic [FIELD_DATAW-1:0] field_data_in,
    output logic [FIELD_ADDRW-1:0] field_addr_write,
    output logic                   field_we,
    input  logic [15:0]            cursor_field_x_prev,
    input  logic [15:0]            cursor_field_y_prev,
    input  logic [15:0]            cursor_x,
    input  logic [15:0]            cursor_y,
    input  logic                   key_pressed
);

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        DIVX,
        DIVY,
        WRITE,
        DONE
    } state_t;

    localparam logic [15:0] MAX_X = 16'(FIELD_WIDTH - 1);
    localparam logic [15:0] MAX_Y = 16'(FIELD_HEIGHT - 1);
    localparam logic [4:0]  LAST_STEP = 5'd16;

    state_t                 state_q, state_d;
    logic [15:0]            cur_x_q, cur_x_d;
    logic [15:0]            cur_y_q, cur_y_d;
    logic [15:0]            prev_x_q, prev_x_d;
    logic [15:0]            prev_y_q, prev_y_d;
    logic                   key_q, key_d;
    logic [15:0]            cx_q, cx_d;
    logic [15:0]            cy_q, cy_d;
    logic                   dx_neg_q, dx_neg_d;
    logic                   dy_neg_q, dy_neg_d;
    logic [16:0]            ady_q, ady_d;
    logic [17:0]            m_q, m_d;
    logic [17:0]            rem_q, rem_d;
    logic [16:0]            dvd_q, dvd_d;
    logic [15:0]            quo_q, quo_d;
    logic [16:0]            xq_q, xq_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [FIELD_ADDRW-1:0] field_addr_q, field_addr_d;
    logic [FIELD_DATAW-1:0] field_data_q, field_data_d;

    logic [15:0]        cx_c, cy_c, px_c, py_c;
    logic signed [16:0] dx_c, dy_c;
    logic [16:0]        adx_c, ady_c;
    logic [17:0]        m_c;
    logic [18:0]        trial;
    logic               ge;
    logic [17:0]        rem_step;
    logic [16:0]        dvd_step;
    logic [16:0]        quo_step;
    logic [31:0]        xn, yn, mag;

    function automatic logic [15:0] clamp(input logic [15:0] v, input logic [15:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            prev_x_q     <= '0;
            prev_y_q     <= '0;
            key_q        <= 1'b0;
            cx_q         <= '0;
            cy_q         <= '0;
            dx_neg_q     <= 1'b0;
            dy_neg_q     <= 1'b0;
            ady_q        <= '0;
            m_q          <= '0;
            rem_q        <= '0;
            dvd_q        <= '0;
            quo_q        <= '0;
            xq_q         <= '0;
            cnt_q        <= '0;
            field_addr_q <= '0;
            field_data_q <= '0;
        end else begin
            state_q      <= state_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            prev_x_q     <= prev_x_d;
            prev_y_q     <= prev_y_d;
            key_q        <= key_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            dx_neg_q     <= dx_neg_d;
            dy_neg_q     <= dy_neg_d;
            ady_q        <= ady_d;
            m_q          <= m_d;
            rem_q        <= rem_d;
            dvd_q        <= dvd_d;
            quo_q        <= quo_d;
            xq_q         <= xq_d;
            cnt_q        <= cnt_d;
            field_addr_q <= field_addr_d;
            field_data_q <= field_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        prev_x_d     = prev_x_q;
        prev_y_d     = prev_y_q;
        key_d        = key_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        dx_neg_d     = dx_neg_q;
        dy_neg_d     = dy_neg_q;
        ady_d        = ady_q;
        m_d          = m_q;
        rem_d        = rem_q;
        dvd_d        = dvd_q;
        quo_d        = quo_q;
        xq_d         = xq_q;
        cnt_d        = cnt_q;
        field_addr_d = field_addr_q;
        field_data_d = field_data_q;

        // Cursor is in pixels, previous position is already in cells.
        cx_c  = clamp(cur_x_q >> CELL_SHIFT, MAX_X);
        cy_c  = clamp(cur_y_q >> CELL_SHIFT, MAX_Y);
        px_c  = clamp(prev_x_q, MAX_X);
        py_c  = clamp(prev_y_q, MAX_Y);
        dx_c  = $signed({1'b0, cx_c}) - $signed({1'b0, px_c});
        dy_c  = $signed({1'b0, cy_c}) - $signed({1'b0, py_c});
        adx_c = dx_c[16] ? 17'(-dx_c) : 17'(dx_c);
        ady_c = dy_c[16] ? 17'(-dy_c) : 17'(dy_c);
        m_c   = {1'b0, adx_c} + {1'b0, ady_c};

        // One restoring-division step on the dividend bits shifted out of dvd_q.
        trial    = {rem_q, dvd_q[16]};
        ge       = (trial >= {1'b0, m_q});
        rem_step = ge ? 18'(trial - {1'b0, m_q}) : trial[17:0];
        dvd_step = {dvd_q[15:0], 1'b0};
        quo_step = {quo_q, ge};

        xn  = dx_neg_q ? (32'd0 - {15'd0, xq_q}) : {15'd0, xq_q};
        yn  = dy_neg_q ? (32'd0 - {15'd0, quo_step}) : {15'd0, quo_step};
        mag = 32'(m_q) << 16;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cur_x_d  = cursor_x;
                    cur_y_d  = cursor_y;
                    prev_x_d = cursor_field_x_prev;
                    prev_y_d = cursor_field_y_prev;
                    key_d    = key_pressed;
                    state_d  = CALC;
                end
            end
            CALC: begin
                cx_d     = cx_c;
                cy_d     = cy_c;
                dx_neg_d = dx_c[16];
                dy_neg_d = dy_c[16];
                ady_d    = ady_c;
                m_d      = m_c;
                rem_d    = 18'(adx_c >> 1);
                dvd_d    = {adx_c[0], 16'd0};
                quo_d    = '0;
                cnt_d    = '0;
                state_d  = (!key_q || m_c == '0) ? DONE : DIVX;
            end
            DIVX: begin
                rem_d = rem_step;
                dvd_d = dvd_step;
                quo_d = quo_step[15:0];
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_STEP) begin
                    xq_d    = quo_step;
                    rem_d   = 18'(ady_q >> 1);
                    dvd_d   = {ady_q[0], 16'd0};
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = DIVY;
                end
            end
            DIVY: begin
                rem_d = rem_step;
                dvd_d = dvd_step;
                quo_d = quo_step[15:0];
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_STEP) begin
                    field_addr_d = FIELD_ADDRW'(32'(cy_q) * FIELD_WIDTH + 32'(cx_q));
                    field_data_d = FIELD_DATAW'({xn, yn, mag});
                    state_d      = WRITE;
                end
            end
            WRITE: state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign field_we         = (state_q == WRITE);
    assign done             = (state_q == DONE);
    assign field_addr_write = field_addr_q;
    assign field_data_in    = field_data_q;

endmodule

// File: tb/tb_update_field.sv
// Randomised self-checking bench for update_field against a plain-arithmetic
// reference model of the cell-vector computation and its cycle timing.
module tb_update_field;

    localparam int FW = 8;
    localparam int FH = 6;
    localparam int DW = 96;
    localparam int CS = 4;
    localparam int AW = $clog2(FW * FH);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          done;
    logic [DW-1:0] field_data_in;
    logic [AW-1:0] field_addr_write;
    logic          field_we;
    logic [15:0]   cursor_field_x_prev;
    logic [15:0]   cursor_field_y_prev;
    logic [15:0]   cursor_x;
    logic [15:0]   cursor_y;
    logic          key_pressed;

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] model_addr = '0;
    logic [DW-1:0] model_data = '0;

    update_field #(
        .FIELD_WIDTH (FW),
        .FIELD_HEIGHT(FH),
        .FIELD_DATAW (DW),
        .CELL_SHIFT  (CS)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .done               (done),
        .field_data_in      (field_data_in),
        .field_addr_write   (field_addr_write),
        .field_we           (field_we),
        .cursor_field_x_prev(cursor_field_x_prev),
        .cursor_field_y_prev(cursor_field_y_prev),
        .cursor_x           (cursor_x),
        .cursor_y           (cursor_y),
        .key_pressed        (key_pressed)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int clampi(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    // Runs one operation; inject>0 pulses start at that cycle, rst_at>0 resets at that cycle.
    task automatic applyStimulus(input int px, input int py, input int ux, input int uy,
                                 input bit key, input int inject, input int rst_at);
        int cx, cy, pcx, pcy, dx, dy, adx, ady, m, qx, qy;
        int we_cnt, done_cnt, we_cyc, done_cyc, overlap;
        bit wr;
        logic [31:0] xn, yn, mag;
        logic [AW-1:0] exp_addr, got_addr;
        logic [DW-1:0] exp_data, got_data;

        cx  = clampi(ux >> CS, FW - 1);
        cy  = clampi(uy >> CS, FH - 1);
        pcx = clampi(px, FW - 1);
        pcy = clampi(py, FH - 1);
        dx  = cx - pcx;
        dy  = cy - pcy;
        adx = (dx < 0) ? -dx : dx;
        ady = (dy < 0) ? -dy : dy;
        m   = adx + ady;
        wr  = key && (m != 0);
        qx  = wr ? (adx * 65536) / m : 0;
        qy  = wr ? (ady * 65536) / m : 0;
        xn  = 32'((dx < 0) ? -qx : qx);
        yn  = 32'((dy < 0) ? -qy : qy);
        mag = 32'(m * 65536);
        exp_addr = AW'(cy * FW + cx);
        exp_data = {xn, yn, mag};

        we_cnt = 0; done_cnt = 0; we_cyc = 0; done_cyc = 0; overlap = 0;
        got_addr = '0; got_data = '0;

        @(negedge clk);
        cursor_field_x_prev = 16'(px);
        cursor_field_y_prev = 16'(py);
        cursor_x    = 16'(ux);
        cursor_y    = 16'(uy);
        key_pressed = key;
        start       = 1'b1;

        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (n == 1) begin
                checkOutput("hold_addr_pre", field_addr_write, model_addr);
                checkOutput("hold_data_pre", field_data_in, model_data);
            end
            if (field_we) begin
                we_cnt++;
                we_cyc   = n;
                got_addr = field_addr_write;
                got_data = field_data_in;
            end
            if (done) begin
                done_cnt++;
                done_cyc = n;
            end
            if (field_we && done) overlap++;
            if (rst_at > 0 && n == rst_at + 1) begin
                checkOutput("rst_addr_zero", field_addr_write, '0);
                checkOutput("rst_data_zero", field_data_in, '0);
                checkOutput("rst_we_zero", field_we, 1'b0);
                checkOutput("rst_done_zero", done, 1'b0);
            end
            reset = (rst_at > 0 && n == rst_at);
            start = (inject > 0 && n == inject);
            cursor_field_x_prev = 16'($urandom);
            cursor_field_y_prev = 16'($urandom);
            cursor_x    = 16'($urandom);
            cursor_y    = 16'($urandom);
            key_pressed = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        reset = 1'b0;

        if (rst_at > 0) begin
            checkOutput("rst_we_count", we_cnt, 0);
            checkOutput("rst_done_count", done_cnt, 0);
            model_addr = '0;
            model_data = '0;
        end else begin
            checkOutput("we_count", we_cnt, wr ? 1 : 0);
            checkOutput("done_count", done_cnt, 1);
            checkOutput("done_cycle", done_cyc, wr ? 37 : 2);
            checkOutput("we_done_overlap", overlap, 0);
            if (wr) begin
                checkOutput("we_cycle", we_cyc, 36);
                checkOutput("write_addr", got_addr, exp_addr);
                checkOutput("write_data", got_data, exp_data);
                model_addr = exp_addr;
                model_data = exp_data;
            end
        end
        checkOutput("hold_addr_post", field_addr_write, model_addr);
        checkOutput("hold_data_post", field_data_in, model_data);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        cursor_field_x_prev = '0;
        cursor_field_y_prev = '0;
        cursor_x    = '0;
        cursor_y    = '0;
        key_pressed = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_done", done, 1'b0);
        checkOutput("reset_we", field_we, 1'b0);
        checkOutput("reset_addr", field_addr_write, '0);
        checkOutput("reset_data", field_data_in, '0);

        // Start together with reset must be dropped; otherwise done would appear at cycle 2.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checkOutput("reset_prio_done", done, 1'b0);
        end

        for (int r = 0; r < 100; r++)
            applyStimulus(0, 0, 100, 100, 1'b1, (r == 0) ? 5 : 0, 0);
        applyStimulus(7, 5, 0, 0, 1'b1, 0, 0);
        applyStimulus(0, 2, 48, 32, 1'b1, 0, 0);
        applyStimulus(0, 0, 100, 100, 1'b0, 0, 0);
        applyStimulus(1, 1, 16, 16, 1'b1, 0, 0);
        applyStimulus(0, 0, 100, 100, 1'b1, 0, 25);
        applyStimulus(0, 0, 100, 100, 1'b1, 0, 0);

        for (int r = 0; r < 150; r++) begin
            int px, py;
            px = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 9));
            py = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 7));
            applyStimulus(px, py, int'($urandom_range(0, 160)), int'($urandom_range(0, 120)),
                          ($urandom_range(0, 4) != 0), 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
